// File: rtl/uart_rx.sv
// UART receiver: synchronizes rx, recovers 8-bit LSB-first frames with optional
// parity and one or two stop bits, and strobes each byte out for one cycle.
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx,
  input  logic [31:0] baud_cnt_max,
  input  logic [31:0] baud_cnt_max_half,
  input  logic [1:0]  paribit,
  input  logic        stopbit,
  output logic [7:0]  po_data,
  output logic        po_flag,
  output logic        parity_err,
  output logic        frame_err,
  output logic        rx_busy
);

  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARI, STOP1, STOP2, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [NS-1:0] sync_q, sync_d;
  logic        rx_d_q, rx_d_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] max_q, max_d;
  logic [31:0] half_q, half_d;
  logic [1:0]  pari_q, pari_d;
  logic        stop2_q, stop2_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        par_bad_q, par_bad_d;
  logic        stop_bad_q, stop_bad_d;
  logic [7:0]  po_data_q, po_data_d;
  logic        po_flag_q, po_flag_d;
  logic        parity_err_q, parity_err_d;
  logic        frame_err_q, frame_err_d;
  logic        rx_busy_q, rx_busy_d;

  logic rx_s, start_edge, cfg_ok, sample, par_x;

  assign rx_s       = sync_q[NS-1];
  assign start_edge = !rx_s && rx_d_q;
  // Degenerate baud settings would sample outside the bit, so such frames are never started.
  assign cfg_ok     = (baud_cnt_max >= 32'd4) && (baud_cnt_max_half != 32'd0) &&
                      (baud_cnt_max_half < baud_cnt_max);
  assign sample     = (state_q == START) ? (cnt_q == half_q - 32'd1)
                                         : (cnt_q == max_q - 32'd1);
  assign par_x      = (^shift_q) ^ rx_s;

  always_comb begin
    sync_d       = {sync_q[NS-2:0], rx};
    rx_d_d       = rx_s;
    state_d      = state_q;
    cnt_d        = cnt_q + 32'd1;
    max_d        = max_q;
    half_d       = half_q;
    pari_d       = pari_q;
    stop2_d      = stop2_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    par_bad_d    = par_bad_q;
    stop_bad_d   = stop_bad_q;
    po_data_d    = po_data_q;
    po_flag_d    = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    case (state_q)
      IDLE: begin
        cnt_d = 32'd0;
        if (start_edge) begin
          max_d   = baud_cnt_max;
          half_d  = baud_cnt_max_half;
          pari_d  = paribit;
          stop2_d = stopbit;
          if (cfg_ok) begin
            state_d    = START;
            bit_cnt_d  = 3'd0;
            par_bad_d  = 1'b0;
            stop_bad_d = 1'b0;
          end
        end
      end
      START: begin
        if (sample) begin
          cnt_d   = 32'd0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (sample) begin
          cnt_d     = 32'd0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = (pari_q == 2'b00) ? STOP1 : PARI;
        end
      end
      PARI: begin
        if (sample) begin
          cnt_d   = 32'd0;
          state_d = STOP1;
          case (pari_q)
            2'b01:   par_bad_d = !par_x;
            2'b10:   par_bad_d = par_x;
            default: par_bad_d = 1'b0;
          endcase
        end
      end
      STOP1: begin
        if (sample) begin
          cnt_d = 32'd0;
          if (!rx_s) stop_bad_d = 1'b1;
          state_d = stop2_q ? STOP2 : DONE;
        end
      end
      STOP2: begin
        if (sample) begin
          cnt_d = 32'd0;
          if (!rx_s) stop_bad_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        cnt_d        = 32'd0;
        po_data_d    = shift_q;
        parity_err_d = par_bad_q;
        frame_err_d  = stop_bad_q;
        po_flag_d    = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        cnt_d   = 32'd0;
        state_d = IDLE;
      end
    endcase

    rx_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      sync_q       <= '1;
      rx_d_q       <= 1'b1;
      cnt_q        <= 32'd0;
      max_q        <= 32'd0;
      half_q       <= 32'd0;
      pari_q       <= 2'b00;
      stop2_q      <= 1'b0;
      shift_q      <= 8'd0;
      bit_cnt_q    <= 3'd0;
      par_bad_q    <= 1'b0;
      stop_bad_q   <= 1'b0;
      po_data_q    <= 8'd0;
      po_flag_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_busy_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      rx_d_q       <= rx_d_d;
      cnt_q        <= cnt_d;
      max_q        <= max_d;
      half_q       <= half_d;
      pari_q       <= pari_d;
      stop2_q      <= stop2_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      par_bad_q    <= par_bad_d;
      stop_bad_q   <= stop_bad_d;
      po_data_q    <= po_data_d;
      po_flag_q    <= po_flag_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      rx_busy_q    <= rx_busy_d;
    end
  end

  assign po_data    = po_data_q;
  assign po_flag    = po_flag_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are built bit by bit on the line, and a frame-level
// model predicts byte, error flags and strobe time for each accepted frame.
module tb_uart_rx;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        rx;
  logic [31:0] baud_cnt_max;
  logic [31:0] baud_cnt_max_half;
  logic [1:0]  paribit;
  logic        stopbit;
  logic [7:0]  po_data;
  logic        po_flag;
  logic        parity_err;
  logic        frame_err;
  logic        rx_busy;

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx(rx),
    .baud_cnt_max(baud_cnt_max), .baud_cnt_max_half(baud_cnt_max_half),
    .paribit(paribit), .stopbit(stopbit),
    .po_data(po_data), .po_flag(po_flag), .parity_err(parity_err),
    .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #5 clk_i = ~clk_i;

  localparam int BIT = 16;
  localparam int HALF = 8;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         t;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_flags = 0;
  logic run = 1'b0;
  logic chk_busy = 1'b0;
  logic [7:0] held_d = 8'd0;
  logic held_pe = 1'b0;
  logic held_fe = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    for (int i = 0; i < BIT; i++) begin
      tick(1);
      if (chk_busy && i == HALF) chk("rx_busy_in_frame", int'(rx_busy), 1);
    end
  endtask

  // Whole frame on the line plus its prediction from the frame rules.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic sb,
                            input logic par_b, input logic s1, input logic s2);
    exp_t e;
    int   nbits;
    paribit = pm;
    stopbit = sb;
    nbits = 8 + ((pm != 2'b00) ? 1 : 0) + 1 + (sb ? 1 : 0);
    e.d  = d;
    e.pe = (pm == 2'b01) ? ((^d) == par_b) :
           (pm == 2'b10) ? ((^d) != par_b) : 1'b0;
    e.fe = !s1 || (sb && !s2);
    e.t  = cyc + 2 + 1 + HALF + nbits * BIT + 2;
    q.push_back(e);
    chk_busy = 1'b1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pm != 2'b00) drive_bit(par_b);
    drive_bit(s1);
    if (sb) drive_bit(s2);
    chk_busy = 1'b0;
    rx = 1'b1;
  endtask

  always @(negedge clk_i) begin
    if (run && !rst_i) begin
      if (po_flag) begin
        n_flags++;
        if (q.size() == 0) begin
          chk("spurious_po_flag", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("po_data", int'(po_data), int'(e.d));
          chk("parity_err", int'(parity_err), int'(e.pe));
          chk("frame_err", int'(frame_err), int'(e.fe));
          n_cmp++;
          if (cyc < e.t - 1 || cyc > e.t + 1) begin
            n_bad++;
            $display("FAIL latency: flag at cycle %0d expected %0d +/-1", cyc, e.t);
          end
          held_d  = e.d;
          held_pe = e.pe;
          held_fe = e.fe;
        end
      end else begin
        chk("hold_po_data", int'(po_data), int'(held_d));
        chk("hold_parity_err", int'(parity_err), int'(held_pe));
        chk("hold_frame_err", int'(frame_err), int'(held_fe));
      end
    end
  end

  initial begin
    int f0;
    logic [7:0] pb;
    rst_i = 1'b1;
    rx = 1'b1;
    baud_cnt_max = 32'd16;
    baud_cnt_max_half = 32'd8;
    paribit = 2'b00;
    stopbit = 1'b0;
    tick(3);
    chk("reset_po_data", int'(po_data), 0);
    chk("reset_po_flag", int'(po_flag), 0);
    chk("reset_parity_err", int'(parity_err), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_rx_busy", int'(rx_busy), 0);
    rst_i = 1'b0;
    run = 1'b1;
    tick(5);

    send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(30);
    chk("a5_data", int'(po_data), 'hA5);
    chk("a5_flags", int'(n_flags), 1);
    chk("a5_busy_after", int'(rx_busy), 0);

    send_frame(8'h03, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(30);
    chk("even_ok_perr", int'(parity_err), 0);
    send_frame(8'h03, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
    tick(30);
    chk("even_bad_perr", int'(parity_err), 1);
    chk("even_bad_data", int'(po_data), 'h03);
    chk("even_flags", int'(n_flags), 3);

    send_frame(8'h80, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(30);
    chk("odd_data", int'(po_data), 'h80);
    chk("odd_perr", int'(parity_err), 0);
    chk("odd_ferr", int'(frame_err), 1);

    f0 = n_flags;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    chk("glitch_no_flag", n_flags, f0);
    chk("glitch_idle", int'(rx_busy), 0);
    chk("glitch_hold_data", int'(po_data), 'h80);

    paribit = 2'b00;
    stopbit = 1'b0;
    pb = 8'h3C;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(pb[i]);
    rx = pb[4];
    tick(HALF);
    rst_i = 1'b1;
    tick(2);
    held_d = 8'd0;
    held_pe = 1'b0;
    held_fe = 1'b0;
    rx = 1'b1;
    rst_i = 1'b0;
    tick(1);
    chk("midreset_data", int'(po_data), 0);
    chk("midreset_ferr", int'(frame_err), 0);
    chk("midreset_busy", int'(rx_busy), 0);
    tick(40);
    chk("midreset_no_flag", n_flags, f0);
    send_frame(8'h5A, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(30);
    chk("after_reset_data", int'(po_data), 'h5A);

    f0 = n_flags;
    send_frame(8'h00, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(8'hFF, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(8'h55, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(40);
    chk("loopback_flags", n_flags - f0, 3);
    chk("loopback_last", int'(po_data), 'h55);
    chk("loopback_perr", int'(parity_err), 0);

    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin baud_cnt_max = 32'd3;  baud_cnt_max_half = 32'd1; end
        1: begin baud_cnt_max = 32'd16; baud_cnt_max_half = 32'd0; end
        default: begin baud_cnt_max = 32'd16; baud_cnt_max_half = 32'd16; end
      endcase
      f0 = n_flags;
      rx = 1'b0;
      tick(3);
      chk("badcfg_idle", int'(rx_busy), 0);
      tick(BIT);
      rx = 1'b1;
      tick(3 * BIT);
      chk("badcfg_no_flag", n_flags, f0);
    end
    baud_cnt_max = 32'd16;
    baud_cnt_max_half = 32'd8;

    for (int i = 0; i < 400 && q.size() != 0; i++) tick(1);
    chk("pending_frames", q.size(), 0);
    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
